// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the signed sequential divider.
package divider_pkg;

    localparam int unsigned DVD_W = 49;
    localparam int unsigned DVS_W = 25;
    localparam int unsigned QB_W  = 24;

    localparam logic [DVS_W-1:0] SAT_POS = 25'h0FFFFFF;
    localparam logic [DVS_W-1:0] SAT_NEG = 25'h1000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/divider_if.sv
// Start/operand/result bundle between a requester and the divider.
interface divider_if;
    import divider_pkg::*;

    logic               en;
    logic [DVD_W-1:0]   dividend;
    logic [DVS_W-1:0]   divisor;
    logic [DVS_W-1:0]   quotient;
    logic [DVS_W-1:0]   remainder;
    logic               busy;
    logic               done;
    logic               dz;
    logic               ovf;

    modport master (
        output en, dividend, divisor,
        input  quotient, remainder, busy, done, dz, ovf
    );

    modport slave (
        input  en, dividend, divisor,
        output quotient, remainder, busy, done, dz, ovf
    );

endinterface

// File: rtl/divider_step.sv
// One radix-2 restoring step on magnitudes: shift in a dividend bit, subtract if it fits.
module divider_step (
    input  logic [25:0] r_i,
    input  logic        bit_i,
    input  logic [24:0] dvs_i,
    output logic [25:0] r_o,
    output logic        q_o
);

    logic [26:0] t;

    // Trial subtraction; the result always fits 26 bits because r < divisor
    always_comb begin
        t   = {r_i, bit_i};
        q_o = 1'b0;
        r_o = t[25:0];
        if (t >= {2'b00, dvs_i}) begin
            q_o = 1'b1;
            r_o = 26'(t - {2'b00, dvs_i});
        end
    end

endmodule

// File: rtl/divider.sv
// Signed 49/25 sequential divider: sign split, 24 restoring steps, sign fix-up.
// All state updates on the falling clock edge; reset is asynchronous, active-low.
module divider
    import divider_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    divider_if.slave    bus
);

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [25:0]        r_q, r_d;
    logic [QB_W-1:0]    s_q, s_d;
    logic [QB_W-1:0]    q_q, q_d;
    logic [DVS_W-1:0]   dvs_q, dvs_d;
    logic               sdvd_q, sdvd_d;
    logic               sdvs_q, sdvs_d;
    logic               dzp_q, dzp_d;
    logic               ovfp_q, ovfp_d;
    logic [DVS_W-1:0]   quo_q, quo_d;
    logic [DVS_W-1:0]   rem_q, rem_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;

    logic [DVD_W-1:0]   dvd_mag;
    logic [DVS_W-1:0]   dvs_mag;
    logic               dz_c, ovf_c;
    logic [25:0]        step_r;
    logic               step_q;

    divider_step u_step (
        .r_i   (r_q),
        .bit_i (s_q[QB_W-1]),
        .dvs_i (dvs_q),
        .r_o   (step_r),
        .q_o   (step_q)
    );

    // Operand magnitudes and error detection on the live inputs
    always_comb begin
        dvd_mag = bus.dividend[DVD_W-1] ? (~bus.dividend + 49'd1) : bus.dividend;
        dvs_mag = bus.divisor[DVS_W-1]  ? (~bus.divisor + 25'd1)  : bus.divisor;
        dz_c    = (dvs_mag == '0);
        ovf_c   = !dz_c && (dvd_mag[DVD_W-1:QB_W] >= dvs_mag);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        s_d     = s_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        sdvd_d  = sdvd_q;
        sdvs_d  = sdvs_q;
        dzp_d   = dzp_q;
        ovfp_d  = ovfp_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    sdvd_d = bus.dividend[DVD_W-1];
                    sdvs_d = bus.divisor[DVS_W-1];
                    dvs_d  = dvs_mag;
                    dzp_d  = dz_c;
                    ovfp_d = ovf_c;
                    if (dz_c || ovf_c) begin
                        state_d = FIX;
                    end else begin
                        r_d     = {1'b0, dvd_mag[DVD_W-1:QB_W]};
                        s_d     = dvd_mag[QB_W-1:0];
                        q_d     = '0;
                        cnt_d   = 5'd23;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d = step_r;
                s_d = {s_q[QB_W-2:0], 1'b0};
                q_d = {q_q[QB_W-2:0], step_q};
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FIX: begin
                if (dzp_q || ovfp_q) begin
                    quo_d = (sdvd_q == sdvs_q) ? SAT_POS : SAT_NEG;
                    rem_d = '0;
                end else begin
                    quo_d = (sdvd_q != sdvs_q) ? (~{1'b0, q_q} + 25'd1) : {1'b0, q_q};
                    rem_d = sdvd_q ? (~r_q[DVS_W-1:0] + 25'd1) : r_q[DVS_W-1:0];
                end
                dz_d    = dzp_q;
                ovf_d   = ovfp_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers on the falling edge
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            s_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            sdvd_q  <= 1'b0;
            sdvs_q  <= 1'b0;
            dzp_q   <= 1'b0;
            ovfp_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            s_q     <= s_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            sdvd_q  <= sdvd_d;
            sdvs_q  <= sdvs_d;
            dzp_q   <= dzp_d;
            ovfp_q  <= ovfp_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.dz        = dz_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_divider.sv
// Randomized scoreboard bench for the signed divider.
module tb_divider;

    typedef struct {
        logic [24:0] q;
        logic [24:0] r;
        logic        dz;
        logic        ovf;
        int unsigned done_edge;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned edge_cnt;
    int unsigned next_free;
    int unsigned n_cmp;
    int unsigned n_bad;
    exp_t        sb[$];

    divider_if bus ();

    divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count active (falling) edges to time results against E0
    initial edge_cnt = 0;
    always @(negedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    // Reference: plain signed integer division with range check
    function automatic exp_t model(input logic [48:0] a_bits, input logic [24:0] b_bits);
        exp_t e;
        logic signed [48:0] as;
        logic signed [24:0] bs;
        longint a, b, qq, rr;
        as = a_bits;
        bs = b_bits;
        a  = as;
        b  = bs;
        e.done_edge = 0;
        e.dz  = (b == 0);
        e.ovf = 1'b0;
        e.q   = '0;
        e.r   = '0;
        if (!e.dz) begin
            qq = a / b;
            rr = a % b;
            e.ovf = (qq >= (64'sd1 <<< 24)) || (qq <= -(64'sd1 <<< 24));
            if (!e.ovf) begin
                e.q = qq[24:0];
                e.r = rr[24:0];
            end
        end
        if (e.dz || e.ovf) begin
            e.q = ((a < 0) == (b < 0)) ? 25'h0FFFFFF : 25'h1000000;
            e.r = '0;
        end
        return e;
    endfunction

    task automatic do_div(input logic [48:0] a, input logic [24:0] b, output int unsigned e0);
        exp_t e;
        @(posedge clk);
        while (edge_cnt + 1 < next_free) @(posedge clk);
        bus.en       = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e0 = edge_cnt + 1;
        e = model(a, b);
        e.done_edge = e0 + ((e.dz || e.ovf) ? 1 : 25);
        sb.push_back(e);
        next_free = e.done_edge + 1;
        @(posedge clk);
        chk("busy_after_E0", 64'(bus.busy), 64'd1);
        bus.en       = 1'b0;
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = $urandom;
    endtask

    // Monitor: every done pulse must match the oldest expected result
    always @(posedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_edge", 64'(edge_cnt), 64'(e.done_edge));
                chk("quotient",  64'(bus.quotient),  64'(e.q));
                chk("remainder", 64'(bus.remainder), 64'(e.r));
                chk("dz",        64'(bus.dz),  64'(e.dz));
                chk("ovf",       64'(bus.ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        int unsigned e0;
        int unsigned guard;
        logic signed [48:0] rd;
        logic signed [24:0] rv;
        n_cmp = 0;
        n_bad = 0;
        next_free = 0;
        reset = 1'b0;
        bus.en = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_quotient",  64'(bus.quotient),  64'd0);
        chk("rst_remainder", 64'(bus.remainder), 64'd0);
        chk("rst_busy",      64'(bus.busy), 64'd0);
        chk("rst_done",      64'(bus.done), 64'd0);
        chk("rst_dz",        64'(bus.dz),   64'd0);
        chk("rst_ovf",       64'(bus.ovf),  64'd0);
        @(posedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Basic divide with an en pulse at E5 that must be ignored
        do_div(49'd1000, 25'd7, e0);
        while (edge_cnt != e0 + 4) @(posedge clk);
        bus.en       = 1'b1;
        bus.dividend = 49'd12345;
        bus.divisor  = 25'd3;
        @(posedge clk);
        bus.en = 1'b0;

        // Back-to-back: accepted at E26, done at E51
        do_div(-49'sd1000, 25'd7, e0);
        do_div(49'h0FFFFFE000001, 25'h0FFFFFF, e0);
        do_div(49'd5, 25'd0, e0);
        do_div(49'h0800000000000, 25'd2, e0);
        do_div(-49'sd5, 25'd0, e0);
        do_div(49'h1000000000000, -25'sd1, e0);
        do_div(49'd1000, -25'sd7, e0);
        do_div(-49'sd1000, -25'sd7, e0);
        do_div(49'h0FFFFFFFFFFFF, 25'h1000000, e0);

        // Reset mid-CALC: in-flight result discarded, outputs cleared
        do_div(49'd999999, 25'd13, e0);
        repeat (8) @(posedge clk);
        reset = 1'b0;
        sb.delete();
        #1;
        chk("midrst_quotient",  64'(bus.quotient),  64'd0);
        chk("midrst_remainder", 64'(bus.remainder), 64'd0);
        chk("midrst_busy",      64'(bus.busy), 64'd0);
        chk("midrst_done",      64'(bus.done), 64'd0);
        chk("midrst_dz",        64'(bus.dz),   64'd0);
        chk("midrst_ovf",       64'(bus.ovf),  64'd0);
        repeat (2) @(posedge clk);
        reset = 1'b1;
        repeat (30) @(posedge clk);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        chk("post_rst_quotient", 64'(bus.quotient), 64'd0);
        next_free = 0;

        // Random operands across a spread of magnitudes
        for (int i = 0; i < 40; i++) begin
            rd = 49'({$urandom, $urandom});
            rd = rd >>> $urandom_range(0, 48);
            rv = 25'($urandom);
            rv = rv >>> $urandom_range(0, 24);
            do_div(rd, rv, e0);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
